jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
Shares a bank of WIDTH JK flip-flop bits among NREQ requesters. Each JK bit is built from an SR core through J/K-to-S/R conversion logic. Each requester issues a per-bit command (hold/reset/set/toggle) through a req/gnt/ack handshake. A round-robin arbiter serialises the commands, and a small FSM drives the J/K inputs of the addressed bit for exactly one clock.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, number of JK bits in the bank (1..32)
AW, max(1,clog2(WIDTH)), derived address width; not overridable

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level; held until ack
cmd  in  2*NREQ  per-requester command, slice i = cmd[2i+1:2i]; 00 hold, 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1)
addr  in  AW*NREQ  per-requester bit index, slice i = addr[AW*i+AW-1:AW*i]
gnt  out  NREQ  one-hot grant, registered
ack  out  1  one-cycle completion pulse to the granted requester
err  out  1  one-cycle pulse coincident with ack when the latched addr >= WIDTH
busy  out  1  high in APPLY and ACK states
q  out  WIDTH  bank state
qb  out  WIDTH  always the bitwise complement of q

Behaviour:
- Reset (async, rst_n=0): state=IDLE, q=0, qb=all ones, gnt=0, ack=0, err=0, busy=0, rr_ptr=0. Any command in flight is dropped and no bit changes.
- FSM states: IDLE, APPLY, ACK.
- IDLE: at a clock edge with any req bit high, the winner is the first requester with req high, searching from rr_ptr upward modulo NREQ.
  - Latch the winner's cmd and addr.
  - gnt[winner]=1, busy=1, next state APPLY.
  - If no req bit is high, stay in IDLE.
- APPLY: J/K for bit latched_addr are decoded from the latched cmd. All other bits get J=K=0.
  - At the edge: that bit updates per JK rules (00 hold, 01 clear, 10 set, 11 invert).
  - rr_ptr <= (winner+1) mod NREQ, ack=1, next state ACK.
  - If latched_addr >= WIDTH: no bit changes and err=1 with the ack.
- ACK: gnt and busy stay high for this cycle.
  - At the next edge: gnt=0, ack=0, err=0, busy=0, next state IDLE.
- Latency: with req high at edge E0, gnt rises after E0, q updates and ack rises after E1, and everything clears after E2. Throughput is 1 command per 3 cycles minimum.
- Handshake rules:
  - The requester holds req, cmd and addr stable until it sees ack.
  - The requester must drop req before edge E3. A req still high at E3 is a new request.
  - cmd/addr changes after E0 have no effect.
- Simultaneous requests: only one winner per arbitration. Losers keep req high and are served in later rounds in round-robin order. No requester waits more than NREQ-1 grants.
- Bit cell: S = J & ~q and R = K & q. The SR core therefore never sees S=R=1, and q/qb are never equal.
- Reset mid-operation: asserting rst_n=0 in APPLY before E1 leaves the bit at its reset value (0). After rst_n deasserts, the FSM restarts in IDLE with rr_ptr=0.
- Hold command (00): runs the full handshake (gnt, ack) and leaves q unchanged.

Decomposition:
- Package jk_bank_pkg:
  - command encodings CMD_HOLD/CMD_RESET/CMD_SET/CMD_TOGGLE
  - FSM state encodings ST_IDLE/ST_APPLY/ST_ACK
  - a clog2 function
- Sub-module jk_bit_cell (ports j, k, clk, rst_n, q, qb): the SR core plus J/K-to-S/R conversion, generated WIDTH times.
- The arbiter, FSM and decode stay in the top module.

Test Plan:
- Reset: drive rst_n=0 with req=4'b1111 -> q=8'h00, qb=8'hFF, gnt=0, ack=0, busy=0. After release, first grant goes to requester 0.
- Single set: requester 1, cmd=10, addr=3 -> gnt=4'b0010 after E0, then q=8'h08 and a one-cycle ack after E1, then gnt=0 after E2.
- Toggle twice: requester 2, cmd=11, addr=0, issued twice -> q goes 8'h01 then 8'h00; qb==~q checked every cycle.
- Arbitration: req=4'b0101 held, rr_ptr=0 -> requester 0 is granted first, then requester 2. Next, req=4'b1111 -> order 3,0,1,2 (rr_ptr=3 after requester 2).
- Reset mid-APPLY: requester 0 sets addr=5 and rst_n pulses low during APPLY -> q stays 8'h00, no ack, FSM in IDLE.
- Out-of-range address: WIDTH=6, addr=7, cmd=10 -> ack and err pulse together for one cycle, q unchanged.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared command/state encodings and width helper for the JK bank arbiter
package jk_bank_pkg;
  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_APPLY = 2'd1, ST_ACK = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/jk_bit_cell.sv
// jk_bit_cell: one JK bit built from an SR core; S/R gating keeps S and R mutually exclusive
module jk_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);
  logic s, r;
  assign s  = j & ~q;
  assign r  = k & q;
  assign qb = ~q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else q <= s ? 1'b1 : r ? 1'b0 : q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbitration of per-bit JK commands onto a shared bank
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = clog2(WIDTH) > 1 ? clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    cmd,
  input  logic [AW*NREQ-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic                 ack,
  output logic                 err,
  output logic                 busy,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qb
);
  localparam int PW = clog2(NREQ) > 1 ? clog2(NREQ) : 1;
  state_t          state, nxt;
  logic [PW-1:0]   rr_ptr, win, lo, hi, pick;
  logic            hit_lo, hit_hi, found, oor, do_j, do_k;
  logic [1:0]      lcmd, pcmd;
  logic [AW-1:0]   laddr, paddr;
  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    lo     = '0;
    hi     = '0;
    pcmd   = '0;
    paddr  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_lo = 1'b1;
        lo     = PW'(i);
        if (PW'(i) >= rr_ptr) begin
          hit_hi = 1'b1;
          hi     = PW'(i);
        end
      end
    end
    found = hit_lo;
    pick  = hit_hi ? hi : lo;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PW'(i)) begin
        pcmd  = cmd[2*i +: 2];
        paddr = addr[AW*i +: AW];
      end
    end
  end
  always_comb begin
    nxt  = state == ST_IDLE ? (found ? ST_APPLY : ST_IDLE) : state == ST_APPLY ? ST_ACK : ST_IDLE;
    busy = state != ST_IDLE;
    ack  = state == ST_ACK;
    oor  = 32'(laddr) >= WIDTH;
    err  = ack && oor;
    do_j = state == ST_APPLY && (lcmd == CMD_SET || lcmd == CMD_TOGGLE);
    do_k = state == ST_APPLY && (lcmd == CMD_RESET || lcmd == CMD_TOGGLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt    <= '0;
      rr_ptr <= '0;
      win    <= '0;
      lcmd   <= '0;
      laddr  <= '0;
    end else if (state == ST_IDLE && found) begin
      win   <= pick;
      gnt   <= NREQ'(1) << pick;
      lcmd  <= pcmd;
      laddr <= paddr;
    end else if (state == ST_APPLY) begin
      rr_ptr <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
    end else if (state == ST_ACK) begin
      gnt <= '0;
    end
  // An out-of-range laddr matches no cell, so the bank is left untouched.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    jk_bit_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (do_j && laddr == AW'(b)),
      .k     (do_k && laddr == AW'(b)),
      .q     (q[b]),
      .qb    (qb[b])
    );
  end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: randomized and directed checks of the JK bank arbiter against a transaction-level model
module tb_jk_bank_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  cmd = '0;
  logic [11:0] addr = '0;
  logic [3:0]  gnt;
  logic        ack, err, busy;
  logic [7:0]  q, qb;
  logic [1:0]  s_req = '0;
  logic [3:0]  s_cmd = '0;
  logic [5:0]  s_addr = '0;
  logic [1:0]  s_gnt;
  logic        s_ack, s_err, s_busy;
  logic [5:0]  s_q, s_qb;
  int          compared = 0;
  int          mismatched = 0;
  logic [7:0]  m_q = '0;
  int          m_rr = 0;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .addr(addr),
    .gnt(gnt), .ack(ack), .err(err), .busy(busy), .q(q), .qb(qb)
  );
  jk_bank_arbiter #(.NREQ(2), .WIDTH(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .req(s_req), .cmd(s_cmd), .addr(s_addr),
    .gnt(s_gnt), .ack(s_ack), .err(s_err), .busy(s_busy), .q(s_q), .qb(s_qb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    compared++;
    if (qb !== ~q || s_qb !== ~s_q) begin
      mismatched++;
      $display("FAIL qb_complement q=%h qb=%h s_q=%h s_qb=%h", q, qb, s_q, s_qb);
    end
  end

  // Reference: first pending requester scanning upward from the round-robin pointer.
  function automatic int m_win(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] m_apply(input logic [7:0] v, input logic [1:0] c, input int a);
    if (c == 2'b01) v[a] = 1'b0;
    else if (c == 2'b10) v[a] = 1'b1;
    else if (c == 2'b11) v[a] = ~v[a];
    return v;
  endfunction

  // Serves one transaction on the main DUT and compares every phase with the model.
  task automatic run_txn(input string tag);
    int w, n;
    logic [7:0] eq;
    logic [3:0] eg;
    w  = m_win(req, m_rr);
    eq = m_apply(m_q, cmd[2*w +: 2], int'(addr[3*w +: 3]));
    eg = 4'(1 << w);
    n  = 0;
    while (gnt === 4'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (gnt !== eg || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_grant gnt=%b busy=%b expected gnt=%b busy=1", tag, gnt, busy, eg);
    end
    @(negedge clk);
    compared++;
    if (ack !== 1'b1 || err !== 1'b0 || gnt !== eg || busy !== 1'b1 || q !== eq) begin
      mismatched++;
      $display("FAIL %s_apply ack=%b err=%b gnt=%b busy=%b q=%h expected ack=1 err=0 gnt=%b busy=1 q=%h",
               tag, ack, err, gnt, busy, q, eg, eq);
    end
    req[w] = 1'b0;
    @(negedge clk);
    compared++;
    if ({gnt, ack, err, busy} !== 7'b0) begin
      mismatched++;
      $display("FAIL %s_clear gnt=%b ack=%b err=%b busy=%b expected all 0", tag, gnt, ack, err, busy);
    end
    m_q  = eq;
    m_rr = (w + 1) % 4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    s_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_q   = '0;
    m_rr  = 0;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    repeat (2) @(negedge clk);
    compared++;
    if (q !== 8'h00 || qb !== 8'hFF || gnt !== 4'b0 || ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state q=%h qb=%h gnt=%b ack=%b err=%b busy=%b expected q=00 qb=ff rest 0",
               q, qb, gnt, ack, err, busy);
    end
    rst_n = 1'b1;
    run_txn("reset_first");
    req = '0;
  endtask

  task automatic test_single_set();
    req = 4'b0010;
    cmd[3:2] = 2'b10;
    addr[5:3] = 3'd3;
    run_txn("single_set");
    compared++;
    if (q !== 8'h08) begin
      mismatched++;
      $display("FAIL single_set_value q=%h expected 08", q);
    end
  endtask

  task automatic test_toggle();
    cmd[5:4] = 2'b11;
    addr[8:6] = 3'd0;
    for (int t = 0; t < 2; t++) begin
      req = 4'b0100;
      run_txn("toggle");
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    cmd  = 8'($urandom);
    addr = 12'($urandom);
    req  = 4'b0101;
    for (int t = 0; t < 2; t++) run_txn("arb_pair");
    req = 4'b1111;
    for (int t = 0; t < 4; t++) run_txn("arb_all");
  endtask

  task automatic test_reset_mid_apply();
    int n;
    do_reset();
    req = 4'b0001;
    cmd[1:0] = 2'b10;
    addr[2:0] = 3'd5;
    n = 0;
    while (gnt === 4'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if (q !== 8'h00 || gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_apply_reset q=%h gnt=%b ack=%b busy=%b expected q=00 gnt=0 ack=0 busy=0", q, gnt, ack, busy);
    end
    req   = '0;
    rst_n = 1'b1;
    m_q   = '0;
    m_rr  = 0;
    @(negedge clk);
    compared++;
    if (q !== 8'h00 || busy !== 1'b0 || ack !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_apply_idle q=%h busy=%b ack=%b expected q=00 busy=0 ack=0", q, busy, ack);
    end
    req = 4'b0110;
    cmd[3:2] = 2'b10;
    addr[5:3] = 3'($urandom);
    run_txn("post_reset");
    req = '0;
  endtask

  task automatic test_out_of_range();
    int n;
    s_req  = 2'b10;
    s_cmd  = 4'b1000;
    s_addr = {3'd7, 3'd0};
    n = 0;
    while (s_gnt === 2'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (s_gnt !== 2'b10) begin
      mismatched++;
      $display("FAIL oor_grant gnt=%b expected 10", s_gnt);
    end
    @(negedge clk);
    compared++;
    if (s_ack !== 1'b1 || s_err !== 1'b1 || s_q !== 6'h00) begin
      mismatched++;
      $display("FAIL oor_apply ack=%b err=%b q=%h expected ack=1 err=1 q=00", s_ack, s_err, s_q);
    end
    s_req = '0;
    @(negedge clk);
    compared++;
    if (s_ack !== 1'b0 || s_err !== 1'b0 || s_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL oor_clear ack=%b err=%b busy=%b expected all 0", s_ack, s_err, s_busy);
    end
    s_req  = 2'b01;
    s_cmd  = 4'b0010;
    s_addr = {3'd0, 3'd5};
    n = 0;
    while (s_gnt === 2'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    compared++;
    if (s_ack !== 1'b1 || s_err !== 1'b0 || s_q !== 6'h20) begin
      mismatched++;
      $display("FAIL edge_addr_apply ack=%b err=%b q=%h expected ack=1 err=0 q=20", s_ack, s_err, s_q);
    end
    s_req = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      req  = 4'($urandom_range(1, 15));
      cmd  = 8'($urandom);
      addr = 12'($urandom);
      while (req != 4'b0) run_txn("random");
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_toggle();
    test_arbitration();
    test_reset_mid_apply();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
